// File: rtl/tybec_leaf_pkg.sv
// Shared constants and helpers for the elastic leaf arithmetic blocks.
package tybec_leaf_pkg;

  localparam int unsigned OPM_STREAM = 0;
  localparam int unsigned OPM_CONST  = 1;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/leaf_sync_fifo.sv
// First-word-fall-through synchronous FIFO with modulo-DEPTH pointers.
module leaf_sync_fifo
  import tybec_leaf_pkg::*;
#(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Empty FIFO presents zero so the output is clean straight after reset.
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= bump(wptr);
      if (do_pop)  rptr <= bump(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/leaf_mul_elastic.sv
// Elastic multiplier leaf: free-running LAT-stage pipeline feeding a credit-guarded FWFT FIFO.
module leaf_mul_elastic
  import tybec_leaf_pkg::*;
#(
  parameter int unsigned        STREAMW   = 34,
  parameter int unsigned        OPMODE    = OPM_CONST,
  parameter logic [STREAMW-1:0] CONST_VAL = STREAMW'(34'h0_0000_0003),
  parameter int unsigned        LAT       = 3,
  parameter int unsigned        DEPTH     = LAT + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid_in1,
  input  logic [STREAMW-1:0] in1,
  input  logic               ivalid_in2,
  input  logic [STREAMW-1:0] in2,
  output logic               iready,
  output logic               ovalid,
  output logic [STREAMW-1:0] out1,
  input  logic               oready
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned SW = CW + 1;

  logic               in_valid;
  logic               accept;
  logic               wr;
  logic               pop;
  logic               empty;
  logic [STREAMW-1:0] op2;
  logic [STREAMW-1:0] prod;
  logic [STREAMW-1:0] pipe [LAT];
  logic [LAT-1:0]     tok;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      occ;
  logic [SW-1:0]      load_next;

  always_comb begin
    if (OPMODE == OPM_CONST) begin
      in_valid = ivalid_in1;
      op2      = CONST_VAL;
    end else begin
      in_valid = ivalid_in1 & ivalid_in2;
      op2      = in2;
    end
  end

  assign accept = in_valid & iready;
  assign wr     = tok[LAT-1];
  assign ovalid = ~empty;
  assign pop    = ovalid & oready;
  // Low STREAMW bits of a two's-complement product equal the unsigned product truncated.
  assign prod   = in1 * op2;

  // FIFO write cancels in the sum: occ' + inflight' = occ + inflight + accept - pop.
  assign load_next = SW'(occ) + SW'(inflight) + SW'(accept) - SW'(pop);

  always_ff @(posedge clk) begin
    pipe[0] <= prod;
    for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tok      <= '0;
      inflight <= '0;
      iready   <= 1'b0;
    end else begin
      tok[0] <= accept;
      for (int unsigned i = 1; i < LAT; i++) tok[i] <= tok[i-1];
      if (accept && !wr)      inflight <= inflight + CW'(1);
      else if (!accept && wr) inflight <= inflight - CW'(1);
      iready <= (load_next < SW'(DEPTH));
    end
  end

  leaf_sync_fifo #(
    .WIDTH (STREAMW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .din   (pipe[LAT-1]),
    .pop   (pop),
    .dout  (out1),
    .empty (empty),
    .count (occ)
  );

endmodule

// File: doc/leaf_mul_elastic.md
LEAF_MUL_ELASTIC -- requirements
Module: leaf_mul_elastic

Interface
REQ-001 The block SHALL have parameter STREAMW, default 34, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter OPMODE, default 1: 0 = in1*in2 from streams, 1 = in1*CONST_VAL.
REQ-003 The block SHALL have parameter CONST_VAL, default 34'h0_0000_0003, used as the second operand when OPMODE=1.
REQ-004 The block SHALL have parameter LAT, default 3, range 1..8, giving the multiplier pipeline depth in stages.
REQ-005 The block SHALL have parameter DEPTH, default LAT+2, range LAT+1..32, giving the output FIFO entries.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  reset; synchronous, active-low (asserted when 0).
REQ-008 ivalid_in1  in  1  in1 valid.
REQ-009 in1  in  STREAMW  operand 1, two's complement.
REQ-010 ivalid_in2  in  1  in2 valid; ignored when OPMODE=1.
REQ-011 in2  in  STREAMW  operand 2, two's complement; ignored when OPMODE=1.
REQ-012 iready  out  1  block can accept an operand set this cycle.
REQ-013 ovalid  out  1  out1 holds a valid result.
REQ-014 out1  out  STREAMW  result.
REQ-015 oready  in  1  downstream accepts out1 this cycle.

Function
REQ-016 Input valid SHALL be ivalid_in1 & ivalid_in2 when OPMODE=0, and ivalid_in1 alone when OPMODE=1.
REQ-017 An operand set SHALL be accepted on a rising edge where input valid & iready = 1; no other input state is consumed.
REQ-018 The pipeline SHALL be free-running (never stalls), with a 1-bit valid token travelling alongside each data stage.
REQ-019 Result SHALL be the low STREAMW bits of the full 2*STREAMW signed product; no saturation.
REQ-020 Each result SHALL be written to the output FIFO LAT edges after acceptance.
REQ-021 The FIFO SHALL be first-word-fall-through: ovalid = not empty, and out1 = head entry.
REQ-022 The head SHALL be popped on an edge where ovalid & oready = 1.
REQ-023 An in-flight counter SHALL add 1 on accept and subtract 1 on FIFO write; it SHALL be unchanged when both occur on the same edge.
REQ-024 iready SHALL be 1 exactly when (FIFO occupancy + in-flight count) < DEPTH, so the FIFO never overflows.
REQ-025 iready SHALL NOT depend combinationally on oready.
REQ-026 Minimum latency SHALL be LAT+1 cycles: data accepted at edge t gives ovalid=1 after edge t+LAT when the FIFO is empty.
REQ-027 Full sustained throughput SHALL be one result per cycle while oready=1.
REQ-028 A simultaneous FIFO write and pop SHALL leave occupancy unchanged; a write and pop on an empty FIFO SHALL be legal across consecutive edges only.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH, with DEPTH not required to be a power of two.
REQ-030 When oready=0, out1 and ovalid SHALL be held stable while ovalid=1.
REQ-031 Results SHALL leave in acceptance order; none SHALL be lost or duplicated.

Reset
REQ-032 While rst=0, on each edge the block SHALL clear the valid tokens, in-flight count, FIFO pointers and occupancy.
REQ-033 While rst=0, ovalid SHALL be 0 and iready SHALL be 0.
REQ-034 out1 SHALL be 0 after reset; the data pipeline registers need no reset.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight and buffered results.
REQ-036 iready SHALL rise on the first edge after rst returns to 1.

Structure
REQ-037 Package tybec_leaf_pkg SHALL hold the OPMODE constants (OPM_STREAM=0, OPM_CONST=1) and a clog2-based counter-width function.
REQ-038 The output buffer SHALL be one sub-module, leaf_sync_fifo, parametrised in width and depth, with FWFT, push/pop and count outputs.
REQ-039 Multiplier stages, valid tokens and the credit counter SHALL reside in leaf_mul_elastic.

Verification
REQ-040 OPMODE=1, CONST_VAL=3, oready=1, in1=5 then in1=-2 on consecutive cycles -> out1=15 then 34'h3_FFFF_FFFA, ovalid high on cycles t+4 and t+5.
REQ-041 OPMODE=0, in1=7 with ivalid_in2=0 for 3 cycles, then ivalid_in2=1 with in2=6 -> exactly one accept and one result, out1=42.
REQ-042 Backpressure: oready=0, stream 10 inputs -> iready falls after exactly DEPTH=5 accepts; raising oready drains 5 results in order with no loss.
REQ-043 Streaming: oready toggling 1,0,1,0 for 100 random operands -> the scoreboard matches a truncated signed product model and the FIFO never overflows.
REQ-044 Reset: rst=0 for 1 cycle while 3 items are in flight and 2 are buffered -> ovalid=0 next cycle, no stale results after reset, iready=1 one edge after rst returns to 1.
REQ-045 Wrap: DEPTH=5 with 1000 items at random oready -> pointer wrap exercised, order preserved, in-flight count returns to 0.
